alu_divider: RTL and testbench

- Iterative 32-bit integer divider in the ALU execute stage; the division counterpart of the multiplier unit, with the same opcode/src/result/busy/done interface.
- Computes the quotient (DIV/DIVU) or remainder (MOD/MODU), signed or unsigned, with a radix-2 restoring algorithm at one bit per cycle.
- A one-entry result cache returns the partner result (quotient after remainder, or remainder after quotient) for the same operands in one cycle.

---
 rtl/alu_divider.sv | 189 ++++++++++++++++++
 tb/tb_alu_divider.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_divider.sv
// alu_divider: iterative radix-2 restoring divider for the ALU execute stage.
// Produces the quotient (DIV/DIVU) or remainder (MOD/MODU) after 33 edges.
// A one-entry cache returns the partner result for repeated operands in one cycle.

`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 5
`endif
`ifndef ALU_DIV
`define ALU_DIV  5'd12
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'd13
`endif
`ifndef ALU_MOD
`define ALU_MOD  5'd14
`endif
`ifndef ALU_MODU
`define ALU_MODU 5'd15
`endif

module alu_divider #(
  parameter bit ENABLE_CACHE = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [`ALU_OPCODE_WIDTH-1:0] opcode,
  input  logic [31:0]                  src1,
  input  logic [31:0]                  src2,
  output logic [31:0]                  result,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;      // dividend magnitude; quotient bits shift in at the LSB
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        mod_q, mod_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cvalid_q, cvalid_d;
  logic [31:0] csrc1_q, csrc1_d;
  logic [31:0] csrc2_q, csrc2_d;
  logic        csigned_q, csigned_d;
  logic [31:0] cquo_q, cquo_d;
  logic [31:0] crem_q, crem_d;

  logic        is_div, op_signed, op_mod, hit;
  logic [33:0] rem_sh, trial;
  logic [31:0] quo_fix, rem_fix;

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      mod_q     <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cvalid_q  <= 1'b0;
      csrc1_q   <= '0;
      csrc2_q   <= '0;
      csigned_q <= 1'b0;
      cquo_q    <= '0;
      crem_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      mod_q     <= mod_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cvalid_q  <= cvalid_d;
      csrc1_q   <= csrc1_d;
      csrc2_q   <= csrc2_d;
      csigned_q <= csigned_d;
      cquo_q    <= cquo_d;
      crem_q    <= crem_d;
    end
  end

  // Next-state logic: accept/cache/zero-divisor in IDLE, one bit per CALC edge, sign fixup in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    mod_d     = mod_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cvalid_d  = cvalid_q;
    csrc1_d   = csrc1_q;
    csrc2_d   = csrc2_q;
    csigned_d = csigned_q;
    cquo_d    = cquo_q;
    crem_d    = crem_q;

    is_div    = (opcode == `ALU_DIV) || (opcode == `ALU_DIVU) ||
                (opcode == `ALU_MOD) || (opcode == `ALU_MODU);
    op_signed = (opcode == `ALU_DIV) || (opcode == `ALU_MOD);
    op_mod    = (opcode == `ALU_MOD) || (opcode == `ALU_MODU);
    hit       = ENABLE_CACHE && cvalid_q && (src1 == csrc1_q) &&
                (src2 == csrc2_q) && (op_signed == csigned_q);

    rem_sh    = {1'b0, rem_q, dvd_q[31]};
    trial     = rem_sh - {2'b00, dvs_q};
    quo_fix   = qneg_q ? (32'd0 - dvd_q) : dvd_q;
    rem_fix   = rneg_q ? (32'd0 - rem_q) : rem_q;

    unique case (state_q)
      IDLE: begin
        if (is_div) begin
          if (hit) begin
            result_d = op_mod ? crem_q : cquo_q;
            done_d   = 1'b1;
          end else if (src2 == '0) begin
            result_d = op_mod ? src1 : '1;
            done_d   = 1'b1;
          end else begin
            dvd_d   = (op_signed && src1[31]) ? (32'd0 - src1) : src1;
            dvs_d   = (op_signed && src2[31]) ? (32'd0 - src2) : src2;
            qneg_d  = op_signed && (src1[31] ^ src2[31]);
            rneg_d  = op_signed && src1[31];
            mod_d   = op_mod;
            rem_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = CALC;
            // Cache operand fields double as the in-flight operand latch; the
            // entry stays invalid until FIX, and an abort clears it via reset.
            cvalid_d  = 1'b0;
            csrc1_d   = src1;
            csrc2_d   = src2;
            csigned_d = op_signed;
          end
        end
      end
      CALC: begin
        if (!trial[33]) begin
          rem_d = trial[31:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        cquo_d   = quo_fix;
        crem_d   = rem_fix;
        cvalid_d = 1'b1;
        result_d = mod_q ? rem_fix : quo_fix;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: latency, cache hits, zero divisor, overflow,
// asynchronous reset mid-operation, and a small randomized q/r sweep.

`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 5
`endif
`ifndef ALU_DIV
`define ALU_DIV  5'd12
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'd13
`endif
`ifndef ALU_MOD
`define ALU_MOD  5'd14
`endif
`ifndef ALU_MODU
`define ALU_MODU 5'd15
`endif

module tb_alu_divider;

  logic                         CLK = 1'b0;
  logic                         RST_N = 1'b0;
  logic [`ALU_OPCODE_WIDTH-1:0] opcode = '0;
  logic [31:0]                  src1 = '0;
  logic [31:0]                  src2 = '0;
  logic [31:0]                  result;
  logic                         busy;
  logic                         done;

  int vectors = 0;
  int miscompares = 0;

  alu_divider #(.ENABLE_CACHE(1'b1)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .opcode (opcode),
    .src1   (src1),
    .src2   (src2),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to done; exp_lat is edges from accept to done.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic busy_bad;
    @(negedge CLK);
    opcode = op; src1 = a; src2 = b;
    @(posedge CLK);
    #1;
    opcode = '0; src1 = 32'hDEAD_BEEF; src2 = 32'h0BAD_F00D;
    lat = 0;
    busy_bad = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge CLK);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy_during"}, {31'd0, busy_bad}, 32'd0);
    check({tag, "_result"}, result, exp);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    @(posedge CLK);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        sgn;
    int          n;

    // Reset state
    #12;
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Basic unsigned divide
    run_op("divu_ffff", `ALU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);

    // Cache behaviour with signed operands
    run_op("div_7_m2", `ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("mod_7_m2_hit", `ALU_MOD, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    run_op("modu_7_m2_miss", `ALU_MODU, 32'd7, 32'hFFFF_FFFE, 32'h0000_0007, 33);

    // Negative dividend
    run_op("div_m7_2", `ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("mod_m7_2_hit", `ALU_MOD, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);

    // Divide by zero
    run_op("div_by0", `ALU_DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("modu_by0", `ALU_MODU, 32'h1234, 32'd0, 32'h0000_1234, 0);

    // Signed overflow
    run_op("div_ovf", `ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("mod_ovf_hit", `ALU_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

    // Non-divide opcode leaves outputs untouched
    @(negedge CLK);
    opcode = 5'd3; src1 = 32'd100; src2 = 32'd7;
    repeat (3) @(posedge CLK);
    #1;
    opcode = '0;
    check("nop_done", {31'd0, done}, 32'd0);
    check("nop_busy", {31'd0, busy}, 32'd0);
    check("nop_result", result, 32'h0000_0000);

    // Asynchronous reset ten cycles into a DIVU
    @(negedge CLK);
    opcode = `ALU_DIVU; src1 = 32'd256; src2 = 32'd7;
    @(posedge CLK);
    #1;
    opcode = '0;
    repeat (10) @(posedge CLK);
    #2;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (done === 1'b1) n++;
    end
    check("abort_no_done", n, 32'd0);
    run_op("divu_after_rst", `ALU_DIVU, 32'd256, 32'd7, 32'h0000_0024, 33);
    run_op("modu_after_rst_hit", `ALU_MODU, 32'd256, 32'd7, 32'h0000_0004, 0);

    // Randomized sweep against a behavioural model plus the q*d+r identity
    for (int i = 0; i < 8; i++) begin
      sgn = i[0];
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd3;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
      if (sgn) begin
        eq = $signed(a) / $signed(b);
        er = $signed(a) % $signed(b);
      end else begin
        eq = a / b;
        er = a % b;
      end
      run_op("rnd_q", sgn ? `ALU_DIV : `ALU_DIVU, a, b, eq, 33);
      run_op("rnd_r", sgn ? `ALU_MOD : `ALU_MODU, a, b, er, 0);
      check("rnd_identity", eq * b + er, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
